output_drain: RTL and testbench

- Sits directly downstream of the convolution datapath (MAC plus controller FSM).
- Takes each finished accumulator result with its (x, y, ch) tag and requantizes it from ACC_WIDTH down to OUT_WIDTH by shift, round and saturate.
- Buffers results in a small FIFO and presents them to the host/testbench over a valid/ready interface.
- Counts drained outputs and raises done once the whole feature map has left the chip. Also returns an almost-full stall to the controller.

---
 rtl/output_drain_if.sv | 50 +++++
 rtl/output_drain.sv | 203 ++++++++++++++++++++
 tb/tb_output_drain.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_drain_if.sv
// output_drain_if: bundles the accumulator push bus, the host drain bus
// and the status flags of output_drain.
//   start                    : one-cycle arm pulse for a new layer
//   acc_in/acc_x/acc_y/acc_ch: accumulator result and its tags
//   acc_valid                : push strobe (no ready, push-only)
//   stall                    : FIFO nearly full, producer must hold off
//   out/out_x/out_y/out_ch   : FIFO head, requantized result and tags
//   out_valid/out_ready      : host drain handshake
//   fifo_level               : FIFO occupancy
//   overflow                 : sticky, a push was dropped
//   done                     : whole feature map accepted by the host
// master = producer/host side, slave = output_drain.
`timescale 1ns/1ps
interface output_drain_if #(
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned X_WIDTH     = 10,
    parameter int unsigned Y_WIDTH     = 10,
    parameter int unsigned CH_WIDTH    = 6,
    parameter int unsigned LEVEL_WIDTH = 4
);
    logic                        start;
    logic signed [ACC_WIDTH-1:0] acc_in;
    logic                        acc_valid;
    logic [X_WIDTH-1:0]          acc_x;
    logic [Y_WIDTH-1:0]          acc_y;
    logic [CH_WIDTH-1:0]         acc_ch;
    logic                        stall;
    logic signed [OUT_WIDTH-1:0] out;
    logic [X_WIDTH-1:0]          out_x;
    logic [Y_WIDTH-1:0]          out_y;
    logic [CH_WIDTH-1:0]         out_ch;
    logic                        out_valid;
    logic                        out_ready;
    logic [LEVEL_WIDTH-1:0]      fifo_level;
    logic                        overflow;
    logic                        done;

    modport master (
        output start, acc_in, acc_valid, acc_x, acc_y, acc_ch, out_ready,
        input  stall, out, out_x, out_y, out_ch, out_valid, fifo_level,
               overflow, done
    );

    modport slave (
        input  start, acc_in, acc_valid, acc_x, acc_y, acc_ch, out_ready,
        output stall, out, out_x, out_y, out_ch, out_valid, fifo_level,
               overflow, done
    );
endinterface

// File: rtl/output_drain.sv
// output_drain: requantizes finished accumulator results (round half up,
// arithmetic shift, saturate), buffers them with their (x, y, ch) tags in
// a small FIFO and drains them to the host over valid/ready. Counts the
// drained results and raises done once the whole feature map has left.
// Ports:
//   clk       : clock, all state on rising edge
//   arst_n_in : synchronous, active-high reset (name is historical)
//   bus       : output_drain_if.slave (push bus, drain bus, status)
// Optional build macro OUTPUT_DRAIN_RELU_EN: clamps negative accumulator
// values to zero before rounding (fused ReLU).
`timescale 1ns/1ps
module output_drain #(
    parameter int unsigned ACC_WIDTH          = 32,
    parameter int unsigned OUT_WIDTH          = 16,
    parameter int unsigned OUTPUT_SCALE       = 0,
    parameter int unsigned FIFO_DEPTH         = 8,
    parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
    parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
    parameter int unsigned OUTPUT_NB_CHANNELS = 64
) (
    input  logic           clk,
    input  logic           arst_n_in,
    output_drain_if.slave  bus
);

    localparam int unsigned XW     = $clog2(FEATURE_MAP_WIDTH);
    localparam int unsigned YW     = $clog2(FEATURE_MAP_HEIGHT);
    localparam int unsigned CW     = $clog2(OUTPUT_NB_CHANNELS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned EXT_W  = ACC_WIDTH + 1;
    localparam int unsigned RND_SH = (OUTPUT_SCALE > 0) ? OUTPUT_SCALE - 1 : 0;

    localparam logic [CNT_W-1:0] TOTAL =
        CNT_W'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);

    // Rounding constant is zero when no shift is applied.
    localparam logic signed [EXT_W-1:0] RND_ADD =
        EXT_W'((OUTPUT_SCALE > 0) ? (64'd1 << RND_SH) : 64'd0);

    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q;

    logic signed [OUT_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [XW-1:0]               x_mem_q    [FIFO_DEPTH];
    logic [YW-1:0]               y_mem_q    [FIFO_DEPTH];
    logic [CW-1:0]               ch_mem_q   [FIFO_DEPTH];

    logic                        out_valid_c;
    logic                        push_en_c;
    logic                        pop_en_c;
    logic signed [EXT_W-1:0]     rq_ext_c;
    logic signed [EXT_W-1:0]     rq_rnd_c;
    logic signed [EXT_W-1:0]     rq_shf_c;
    logic signed [OUT_WIDTH-1:0] rq_out_c;

    // Requantize: sign-extend one bit so the rounding add cannot wrap.
    always_comb begin
        rq_ext_c = {bus.acc_in[ACC_WIDTH-1], bus.acc_in};
`ifdef OUTPUT_DRAIN_RELU_EN
        if (bus.acc_in[ACC_WIDTH-1]) begin
            rq_ext_c = '0;
        end
`endif
        rq_rnd_c = rq_ext_c + RND_ADD;
        rq_shf_c = rq_rnd_c >>> OUTPUT_SCALE;
        if (rq_shf_c > SAT_MAX) begin
            rq_out_c = OUT_MAX;
        end else if (rq_shf_c < SAT_MIN) begin
            rq_out_c = OUT_MIN;
        end else begin
            rq_out_c = OUT_WIDTH'(rq_shf_c);
        end
    end

    // Head is visible only while the layer is live.
    assign out_valid_c = (level_q != '0) && ((state_q == RUN) || (state_q == FLUSH));

    // Next-state: FIFO bookkeeping, counters and layer FSM.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        ovf_d     = ovf_q;
        pop_en_c  = out_valid_c && bus.out_ready;
        push_en_c = 1'b0;

        // A full FIFO still accepts a push when the head leaves this cycle.
        if (bus.acc_valid && (state_q == RUN)) begin
            if ((level_q != LVL_W'(FIFO_DEPTH)) || pop_en_c) begin
                push_en_c = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (push_en_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            in_cnt_d = in_cnt_q + CNT_W'(1);
        end
        if (pop_en_c) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end
        case ({push_en_c, pop_en_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    ovf_d     = 1'b0;
                end
            end
            RUN: begin
                if (in_cnt_d == TOTAL) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if ((level_d == '0) && (out_cnt_d == TOTAL)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointers, counters and FIFO storage.
    always_ff @(posedge clk) begin
        if (arst_n_in) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_mem_q[i] <= '0;
                x_mem_q[i]    <= '0;
                y_mem_q[i]    <= '0;
                ch_mem_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ovf_q     <= ovf_d;
            done_q    <= (state_d == DONE);
            if (push_en_c) begin
                data_mem_q[wr_ptr_q] <= rq_out_c;
                x_mem_q[wr_ptr_q]    <= bus.acc_x;
                y_mem_q[wr_ptr_q]    <= bus.acc_y;
                ch_mem_q[wr_ptr_q]   <= bus.acc_ch;
            end
        end
    end

    assign bus.out        = data_mem_q[rd_ptr_q];
    assign bus.out_x      = x_mem_q[rd_ptr_q];
    assign bus.out_y      = y_mem_q[rd_ptr_q];
    assign bus.out_ch     = ch_mem_q[rd_ptr_q];
    assign bus.out_valid  = out_valid_c;
    assign bus.fifo_level = level_q;
    assign bus.stall      = (level_q >= LVL_W'(FIFO_DEPTH - 1));
    assign bus.overflow   = ovf_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_output_drain.sv
// tb_output_drain: drives two output_drain instances (shift 0 and shift 4)
// with identical stimulus and checks both against a queue-based reference.
// The feature map is 4x2x2 (16 results): with a depth-8 FIFO a layer of
// only 8 results would end before the FIFO could ever overflow.
`timescale 1ns/1ps
module tb_output_drain;

    localparam int DEPTH = 8;
    localparam int TOTAL = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               start;
    logic               acc_valid;
    logic               out_ready;
    logic signed [31:0] acc_in;
    logic [1:0]         acc_x;
    logic               acc_y;
    logic               acc_ch;

    output_drain_if #(.ACC_WIDTH(32), .OUT_WIDTH(16), .X_WIDTH(2), .Y_WIDTH(1),
                      .CH_WIDTH(1), .LEVEL_WIDTH(4)) if0 ();
    output_drain_if #(.ACC_WIDTH(32), .OUT_WIDTH(16), .X_WIDTH(2), .Y_WIDTH(1),
                      .CH_WIDTH(1), .LEVEL_WIDTH(4)) if4 ();

    assign if0.start = start;     assign if4.start = start;
    assign if0.acc_in = acc_in;   assign if4.acc_in = acc_in;
    assign if0.acc_valid = acc_valid; assign if4.acc_valid = acc_valid;
    assign if0.acc_x = acc_x;     assign if4.acc_x = acc_x;
    assign if0.acc_y = acc_y;     assign if4.acc_y = acc_y;
    assign if0.acc_ch = acc_ch;   assign if4.acc_ch = acc_ch;
    assign if0.out_ready = out_ready; assign if4.out_ready = out_ready;

    output_drain #(.ACC_WIDTH(32), .OUT_WIDTH(16), .OUTPUT_SCALE(0), .FIFO_DEPTH(DEPTH),
                   .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2))
        dut0 (.clk(clk), .arst_n_in(rst), .bus(if0));
    output_drain #(.ACC_WIDTH(32), .OUT_WIDTH(16), .OUTPUT_SCALE(4), .FIFO_DEPTH(DEPTH),
                   .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2))
        dut4 (.clk(clk), .arst_n_in(rst), .bus(if4));

    typedef struct {
        logic signed [15:0] d0;
        logic signed [15:0] d4;
        logic [1:0]         x;
        logic               y;
        logic               ch;
    } ent_t;

    // Reference: phase 0 idle, 1 run, 2 flush, 3 done.
    ent_t mq[$];
    int   m_phase = 0;
    int   m_in = 0;
    int   m_out = 0;
    bit   m_ovf = 1'b0;

    int checks = 0;
    int errors = 0;

    function automatic logic signed [15:0] ref_q(input longint a, input int s);
        longint v;
        v = a;
`ifdef OUTPUT_DRAIN_RELU_EN
        if (v < 0) v = 0;
`endif
        if (s > 0) v = (v + (longint'(1) << (s - 1))) >>> s;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    function automatic bit m_valid();
        return (mq.size() > 0) && (m_phase == 1 || m_phase == 2);
    endfunction

    task automatic set_push(input logic signed [31:0] v);
        acc_valid = 1'b1;
        acc_in    = v;
        acc_x     = 2'($urandom_range(0, 3));
        acc_y     = 1'($urandom_range(0, 1));
        acc_ch    = 1'($urandom_range(0, 1));
    endtask

    // Advance the reference by one cycle from the current inputs, then clock.
    task automatic tick();
        bit   pop;
        int   sz;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_phase = 0; m_in = 0; m_out = 0; m_ovf = 1'b0;
        end else begin
            pop = m_valid() && out_ready;
            sz  = mq.size();
            if (pop) begin
                void'(mq.pop_front());
                m_out++;
            end
            if (m_phase == 1 && acc_valid) begin
                if (sz < DEPTH || pop) begin
                    e.d0 = ref_q(longint'(acc_in), 0);
                    e.d4 = ref_q(longint'(acc_in), 4);
                    e.x = acc_x; e.y = acc_y; e.ch = acc_ch;
                    mq.push_back(e);
                    m_in++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if ((m_phase == 0 || m_phase == 3) && start) begin
                m_phase = 1; m_in = 0; m_out = 0; m_ovf = 1'b0;
            end else if (m_phase == 1 && m_in == TOTAL) begin
                m_phase = 2;
            end else if (m_phase == 2 && mq.size() == 0 && m_out == TOTAL) begin
                m_phase = 3;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; acc_valid = 1'b0; out_ready = 1'b0;
        acc_in = '0; acc_x = '0; acc_y = 1'b0; acc_ch = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({if0.fifo_level, if0.out_valid, if0.stall, if0.overflow, if0.done} !== 8'd0) begin
            errors++;
            $display("FAIL reset_flags0 got lvl=%0d v=%b st=%b ov=%b dn=%b want all 0",
                     if0.fifo_level, if0.out_valid, if0.stall, if0.overflow, if0.done);
        end
        checks++;
        if ({if4.fifo_level, if4.out_valid, if4.stall, if4.overflow, if4.done} !== 8'd0) begin
            errors++;
            $display("FAIL reset_flags4 got lvl=%0d v=%b want all 0", if4.fifo_level, if4.out_valid);
        end
        checks++;
        if ({if0.out, if0.out_x, if0.out_y, if0.out_ch} !== 20'd0) begin
            errors++;
            $display("FAIL reset_head got out=%0d x=%0d y=%0d ch=%0d want 0",
                     if0.out, if0.out_x, if0.out_y, if0.out_ch);
        end
        set_push(32'sd7);
        tick();
        acc_valid = 1'b0;
        checks++;
        if (if0.fifo_level !== 4'(mq.size()) || if0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_push_ignored got lvl=%0d v=%b want %0d 0", if0.fifo_level,
                     if0.out_valid, mq.size());
        end
    endtask

    task automatic test_stream();
        logic [1:0] tx; logic ty, tch;
        start = 1'b1; tick(); start = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= TOTAL; i++) begin
            set_push(32'(i));
            tx = acc_x; ty = acc_y; tch = acc_ch;
            tick();
            checks++;
            if (if0.out_valid !== 1'b1 || if0.out !== 16'(i) || if4.out !== ref_q(longint'(i), 4)) begin
                errors++;
                $display("FAIL stream_data[%0d] got v=%b out0=%0d out4=%0d want 1 %0d %0d", i,
                         if0.out_valid, if0.out, if4.out, i, ref_q(longint'(i), 4));
            end
            checks++;
            if (if0.out_x !== tx || if0.out_y !== ty || if0.out_ch !== tch) begin
                errors++;
                $display("FAIL stream_tags[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         if0.out_x, if0.out_y, if0.out_ch, tx, ty, tch);
            end
        end
        acc_valid = 1'b0;
        checks++;
        if (if0.done !== 1'b0) begin
            errors++;
            $display("FAIL stream_done_early got %b want 0", if0.done);
        end
        tick();
        checks++;
        if (if0.done !== 1'b1 || if4.done !== 1'b1 || if0.fifo_level !== 4'd0 || if0.overflow !== 1'b0) begin
            errors++;
            $display("FAIL stream_done got dn=%b/%b lvl=%0d ov=%b want 1/1 0 0",
                     if0.done, if4.done, if0.fifo_level, if0.overflow);
        end
    endtask

    task automatic test_requant();
        logic signed [31:0] vals [5];
        logic signed [15:0] exp4 [5];
        logic signed [31:0] v;
        vals[0] = 32'sh18; vals[1] = 32'sh17; vals[2] = -32'sh18;
        vals[3] = 32'sh7FFFFFFF; vals[4] = 32'sh80000000;
`ifdef OUTPUT_DRAIN_RELU_EN
        exp4[0] = 16'sd2; exp4[1] = 16'sd1; exp4[2] = 16'sd0; exp4[3] = 16'sd32767; exp4[4] = 16'sd0;
`else
        exp4[0] = 16'sd2; exp4[1] = 16'sd1; exp4[2] = -16'sd1; exp4[3] = 16'sd32767; exp4[4] = -16'sd32768;
`endif
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (if0.done !== 1'b0 || if0.overflow !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear got dn=%b ov=%b want 0 0", if0.done, if0.overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < TOTAL; i++) begin
            v = (i < 5) ? vals[i] : 32'($urandom());
            set_push(v);
            tick();
            if (i < 5) begin
                checks++;
                if (if4.out !== exp4[i]) begin
                    errors++;
                    $display("FAIL requant_s4[%0d] got %0d want %0d", i, if4.out, exp4[i]);
                end
            end
            checks++;
            if (if0.out !== ref_q(longint'(v), 0) || if4.out !== ref_q(longint'(v), 4)) begin
                errors++;
                $display("FAIL requant_model[%0d] got %0d/%0d want %0d/%0d", i, if0.out, if4.out,
                         ref_q(longint'(v), 0), ref_q(longint'(v), 4));
            end
        end
        acc_valid = 1'b0;
        tick();
        checks++;
        if (if4.done !== 1'b1) begin
            errors++;
            $display("FAIL requant_done got %b want 1", if4.done);
        end
    endtask

    task automatic test_full_overflow();
        logic signed [31:0] sv;
        start = 1'b1; tick(); start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_push(32'($urandom()));
            tick();
            if (i >= 5) begin
                checks++;
                if (if0.fifo_level !== 4'(i + 1) || if0.stall !== (i >= 6)) begin
                    errors++;
                    $display("FAIL fill_level[%0d] got lvl=%0d st=%b want %0d %b", i,
                             if0.fifo_level, if0.stall, i + 1, (i >= 6));
                end
            end
        end
        out_ready = 1'b1;
        sv = 32'($urandom());
        set_push(sv);
        tick();
        checks++;
        if (if0.fifo_level !== 4'd8 || if0.overflow !== 1'b0 || if0.out !== mq[0].d0) begin
            errors++;
            $display("FAIL full_push_pop got lvl=%0d ov=%b head=%0d want 8 0 %0d",
                     if0.fifo_level, if0.overflow, if0.out, mq[0].d0);
        end
        out_ready = 1'b0;
        set_push(32'($urandom()));
        tick();
        checks++;
        if (if0.fifo_level !== 4'd8 || if0.overflow !== 1'b1 || if4.overflow !== 1'b1) begin
            errors++;
            $display("FAIL drop_overflow got lvl=%0d ov=%b/%b want 8 1/1",
                     if0.fifo_level, if0.overflow, if4.overflow);
        end
        acc_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (if0.out_valid !== 1'b1 || if0.out !== mq[0].d0 || if4.out !== mq[0].d4 ||
                if0.out_x !== mq[0].x || if0.out_ch !== mq[0].ch) begin
                errors++;
                $display("FAIL drain[%0d] got v=%b out=%0d/%0d want 1 %0d/%0d", k,
                         if0.out_valid, if0.out, if4.out, mq[0].d0, mq[0].d4);
            end
            if (k == 7) begin
                checks++;
                if (if0.out !== ref_q(longint'(sv), 0)) begin
                    errors++;
                    $display("FAIL drain_last got %0d want %0d", if0.out, ref_q(longint'(sv), 0));
                end
            end
            tick();
        end
        checks++;
        if (if0.fifo_level !== 4'd0 || if0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got lvl=%0d v=%b want 0 0", if0.fifo_level, if0.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(32'($urandom()));
            tick();
        end
        acc_valid = 1'b0;
        checks++;
        if (if0.fifo_level !== 4'd3) begin
            errors++;
            $display("FAIL mid_level got %0d want 3", if0.fifo_level);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (if0.fifo_level !== 4'd0 || if0.out_valid !== 1'b0 || if0.overflow !== 1'b0 ||
            if0.out !== 16'sd0 || if4.fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset got lvl=%0d v=%b ov=%b out=%0d want 0 0 0 0",
                     if0.fifo_level, if0.out_valid, if0.overflow, if0.out);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_push(32'($urandom()));
            tick();
        end
        acc_valid = 1'b0;
        checks++;
        if (if0.fifo_level !== 4'(mq.size()) || if0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ignore got lvl=%0d v=%b want %0d 0",
                     if0.fifo_level, if0.out_valid, mq.size());
        end
    endtask

    task automatic test_random();
        int cyc;
        bit ev;
        cyc = 0;
        start = 1'b1; tick(); start = 1'b0;
        while (m_phase != 3 && cyc < 3000) begin
            if ($urandom_range(0, 3) != 0 && !(if0.stall && $urandom_range(0, 7) != 0))
                set_push(32'($urandom()));
            else
                acc_valid = 1'b0;
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
            cyc++;
            ev = m_valid();
            checks++;
            if (if0.fifo_level !== 4'(mq.size()) || if4.fifo_level !== 4'(mq.size()) ||
                if0.out_valid !== ev || if0.overflow !== m_ovf || if0.done !== (m_phase == 3)) begin
                errors++;
                $display("FAIL rand_ctrl@%0d got lvl=%0d v=%b ov=%b dn=%b want %0d %b %b %b", cyc,
                         if0.fifo_level, if0.out_valid, if0.overflow, if0.done,
                         mq.size(), ev, m_ovf, (m_phase == 3));
            end
            if (ev) begin
                checks++;
                if (if0.out !== mq[0].d0 || if4.out !== mq[0].d4 || if0.out_x !== mq[0].x ||
                    if0.out_y !== mq[0].y || if0.out_ch !== mq[0].ch) begin
                    errors++;
                    $display("FAIL rand_head@%0d got %0d/%0d want %0d/%0d", cyc,
                             if0.out, if4.out, mq[0].d0, mq[0].d4);
                end
            end
        end
        acc_valid = 1'b0;
        checks++;
        if (m_phase != 3 || if0.done !== 1'b1) begin
            errors++;
            $display("FAIL rand_timeout got done=%b after %0d cycles want 1", if0.done, cyc);
        end
    endtask

    task automatic test_relu();
        logic signed [15:0] e_neg;
`ifdef OUTPUT_DRAIN_RELU_EN
        e_neg = 16'sd0;
`else
        e_neg = -16'sd5;
`endif
        start = 1'b1; tick(); start = 1'b0;
        out_ready = 1'b1;
        set_push(-32'sd5);
        tick();
        checks++;
        if (if0.out !== e_neg) begin
            errors++;
            $display("FAIL relu_neg got %0d want %0d", if0.out, e_neg);
        end
        set_push(32'sd300);
        tick();
        checks++;
        if (if0.out !== 16'sd300) begin
            errors++;
            $display("FAIL relu_pos got %0d want 300", if0.out);
        end
        for (int i = 2; i < TOTAL; i++) begin
            set_push(32'($urandom()));
            tick();
        end
        acc_valid = 1'b0;
        tick();
        checks++;
        if (if0.done !== 1'b1) begin
            errors++;
            $display("FAIL relu_done got %b want 1", if0.done);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_requant();
        test_full_overflow();
        test_reset_mid();
        test_random();
        test_relu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
